// File: rtl/jtkiwi_snd_romcache.sv
// Sound-CPU ROM fetch stage for the Kiwi sound subsystem.
// A small direct-mapped cache of 16-bit words sits between the Z80 ROM port
// and the SDRAM ROM slot. Hits answer in the same cycle; misses start a
// single SDRAM read and fill the line when the data strobe arrives.
module jtkiwi_snd_romcache #(
  parameter int          LINES  = 4,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        flush,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_cs,
  output logic        cpu_ok,
  output logic [7:0]  cpu_data,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_data
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 15 - IW;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, next_state;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [15:0]      data_mem [LINES];

  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;
  logic          discard;

  logic [14:0]   waddr;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;
  logic          start_miss;
  logic          fill_now;

  assign waddr = cpu_addr[15:1];
  assign idx   = waddr[IW-1:0];
  assign tag   = waddr[14:IW];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; an ack and strobe arriving together in REQ complete the fetch at once
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cpu_cs && !hit && !flush) next_state = REQ;
      REQ:  if (sdram_ack) next_state = sdram_dst ? IDLE : WAIT;
      WAIT: if (sdram_dst) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Hit detection, CPU outputs and FSM strobes derived from the registered arrays
  always_comb begin
    hit        = valid[idx] && (tag_mem[idx] == tag);
    cpu_ok     = cpu_cs && hit && !flush;
    cpu_data   = cpu_addr[0] ? data_mem[idx][15:8] : data_mem[idx][7:0];
    start_miss = (state == IDLE) && cpu_cs && !hit && !flush;
    fill_now   = ((state == REQ) && sdram_ack && sdram_dst) ||
                 ((state == WAIT) && sdram_dst);
  end

  // SDRAM request handshake and capture of the missing line's index/tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      miss_idx   <= '0;
      miss_tag   <= '0;
    end else begin
      if (start_miss) begin
        sdram_req  <= 1'b1;
        sdram_addr <= OFFSET + {7'd0, waddr};
        miss_idx   <= idx;
        miss_tag   <= tag;
      end else if (state == REQ && sdram_ack) begin
        sdram_req  <= 1'b0;
      end
    end
  end

  // Remember a flush that landed mid-fetch so the stale fill is not marked valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             discard <= 1'b0;
    else if (fill_now || start_miss)     discard <= 1'b0;
    else if (flush && state != IDLE)     discard <= 1'b1;
  end

  // Line storage; flush always beats a fill arriving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (fill_now) begin
        tag_mem[miss_idx]  <= miss_tag;
        data_mem[miss_idx] <= sdram_data;
      end
      if (flush)
        valid <= '0;
      else if (fill_now && !discard)
        valid[miss_idx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtkiwi_snd_romcache.sv
// Directed bench for the sound ROM cache: cold miss, hit, conflict, flush,
// address change mid-fetch, reset mid-fetch and SDRAM address wrap.
module tb_jtkiwi_snd_romcache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic        cpu_cs = 1'b0;
  logic        cpu_ok;
  logic [7:0]  cpu_data;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [15:0] sdram_data = 16'h0;

  logic [15:0] w_addr = 16'h0;
  logic        w_cs = 1'b0;
  logic        w_ok;
  logic [7:0]  w_data;
  logic [21:0] w_sdram_addr;
  logic        w_req;

  int total = 0;
  int bad   = 0;

  jtkiwi_snd_romcache #(.LINES(4), .OFFSET(22'h000100)) dut (
    .rst(rst), .clk(clk), .flush(flush),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_ok(cpu_ok), .cpu_data(cpu_data),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_data(sdram_data)
  );

  jtkiwi_snd_romcache #(.LINES(4), .OFFSET(22'h3FFFF0)) dut_wrap (
    .rst(rst), .clk(clk), .flush(1'b0),
    .cpu_addr(w_addr), .cpu_cs(w_cs), .cpu_ok(w_ok), .cpu_data(w_data),
    .sdram_addr(w_sdram_addr), .sdram_req(w_req), .sdram_ack(1'b0),
    .sdram_dst(1'b0), .sdram_data(16'h0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic handshake(input logic [15:0] d);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b1;
    sdram_data = d;
    tick();
    sdram_dst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    cpu_cs = 1'b1;
    cpu_addr = 16'h0000;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL reset_ok got=%b want=0", cpu_ok); end
    total++; if (sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b want=0", sdram_req); end
    total++; if (sdram_addr !== 22'h0) begin bad++; $display("[TB] FAIL reset_addr got=%h want=0", sdram_addr); end
    total++; if (cpu_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h want=00", cpu_data); end
    cpu_cs = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss();
    cpu_cs = 1'b1;
    cpu_addr = 16'h0000;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL cold_ok0 got=%b want=0", cpu_ok); end
    total++; if (sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL cold_req_early got=%b want=0", sdram_req); end
    tick();
    total++; if (sdram_req !== 1'b1) begin bad++; $display("[TB] FAIL cold_req got=%b want=1", sdram_req); end
    total++; if (sdram_addr !== 22'h000100) begin bad++; $display("[TB] FAIL cold_addr got=%h want=000100", sdram_addr); end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    #1;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL cold_req_drop got=%b want=0", sdram_req); end
    tick();
    total++; if (sdram_req !== 1'b0 || cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL cold_wait got=%b%b want=00", sdram_req, cpu_ok); end
    sdram_dst = 1'b1;
    sdram_data = 16'hBEEF;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL cold_ok_at_dst got=%b want=0", cpu_ok); end
    tick();
    sdram_dst = 1'b0;
    #1;
    total++; if (cpu_ok !== 1'b1) begin bad++; $display("[TB] FAIL cold_ok got=%b want=1", cpu_ok); end
    total++; if (cpu_data !== 8'hEF) begin bad++; $display("[TB] FAIL cold_data got=%h want=EF", cpu_data); end
  endtask

  task automatic test_hit();
    cpu_addr = 16'h0001;
    #1;
    total++; if (cpu_ok !== 1'b1) begin bad++; $display("[TB] FAIL hit_ok got=%b want=1", cpu_ok); end
    total++; if (cpu_data !== 8'hBE) begin bad++; $display("[TB] FAIL hit_data got=%h want=BE", cpu_data); end
    sdram_ack = 1'b1;
    sdram_dst = 1'b1;
    sdram_data = 16'h1111;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    #1;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL hit_noreq got=%b want=0", sdram_req); end
    total++; if (cpu_ok !== 1'b1 || cpu_data !== 8'hBE) begin bad++; $display("[TB] FAIL hit_stray_dst got=%b/%h want=1/BE", cpu_ok, cpu_data); end
  endtask

  task automatic test_conflict();
    cpu_addr = 16'h0008;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL conf_ok0 got=%b want=0", cpu_ok); end
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000104) begin bad++; $display("[TB] FAIL conf_req got=%b/%h want=1/000104", sdram_req, sdram_addr); end
    handshake(16'h1234);
    total++; if (cpu_ok !== 1'b1 || cpu_data !== 8'h34) begin bad++; $display("[TB] FAIL conf_fill got=%b/%h want=1/34", cpu_ok, cpu_data); end
    cpu_addr = 16'h0000;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL conf_evict got=%b want=0", cpu_ok); end
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000100) begin bad++; $display("[TB] FAIL conf_rereq got=%b/%h want=1/000100", sdram_req, sdram_addr); end
    handshake(16'hBEEF);
  endtask

  task automatic test_ack_dst_same();
    cpu_addr = 16'h0020;
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000110) begin bad++; $display("[TB] FAIL same_req got=%b/%h want=1/000110", sdram_req, sdram_addr); end
    sdram_ack = 1'b1;
    sdram_dst = 1'b1;
    sdram_data = 16'hA55A;
    tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    #1;
    total++; if (sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL same_noreq got=%b want=0", sdram_req); end
    total++; if (cpu_ok !== 1'b1 || cpu_data !== 8'h5A) begin bad++; $display("[TB] FAIL same_fill got=%b/%h want=1/5A", cpu_ok, cpu_data); end
  endtask

  task automatic test_flush();
    cpu_addr = 16'h0022;
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000111) begin bad++; $display("[TB] FAIL fl_req got=%b/%h want=1/000111", sdram_req, sdram_addr); end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    flush = 1'b1;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL fl_ok_during got=%b want=0", cpu_ok); end
    tick();
    flush = 1'b0;
    sdram_dst = 1'b1;
    sdram_data = 16'h7777;
    tick();
    sdram_dst = 1'b0;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL fl_discard got=%b want=0", cpu_ok); end
    total++; if (sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL fl_idle got=%b want=0", sdram_req); end
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000111) begin bad++; $display("[TB] FAIL fl_rereq got=%b/%h want=1/000111", sdram_req, sdram_addr); end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    flush = 1'b1;
    sdram_dst = 1'b1;
    sdram_data = 16'h6655;
    tick();
    flush = 1'b0;
    sdram_dst = 1'b0;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL fl_same_dst got=%b want=0", cpu_ok); end
    tick();
    total++; if (sdram_req !== 1'b1) begin bad++; $display("[TB] FAIL fl_rereq2 got=%b want=1", sdram_req); end
    handshake(16'h6655);
    total++; if (cpu_ok !== 1'b1 || cpu_data !== 8'h55) begin bad++; $display("[TB] FAIL fl_refill got=%b/%h want=1/55", cpu_ok, cpu_data); end
    flush = 1'b1;
    #1;
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL fl_hit_mask got=%b want=0", cpu_ok); end
    tick();
    flush = 1'b0;
    #1;
    total++; if (cpu_ok !== 1'b0 || sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL fl_idle_clear got=%b%b want=00", cpu_ok, sdram_req); end
    tick();
    handshake(16'h6655);
  endtask

  task automatic test_addr_change();
    cpu_addr = 16'h0010;
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000108) begin bad++; $display("[TB] FAIL chg_req got=%b/%h want=1/000108", sdram_req, sdram_addr); end
    cpu_addr = 16'h0002;
    handshake(16'hC0DE);
    total++; if (cpu_ok !== 1'b0 || sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL chg_idle got=%b%b want=00", cpu_ok, sdram_req); end
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000101) begin bad++; $display("[TB] FAIL chg_req2 got=%b/%h want=1/000101", sdram_req, sdram_addr); end
    handshake(16'hF00D);
    total++; if (cpu_ok !== 1'b1 || cpu_data !== 8'h0D) begin bad++; $display("[TB] FAIL chg_fill2 got=%b/%h want=1/0D", cpu_ok, cpu_data); end
    cpu_addr = 16'h0011;
    #1;
    total++; if (cpu_ok !== 1'b1 || cpu_data !== 8'hC0) begin bad++; $display("[TB] FAIL chg_fill1 got=%b/%h want=1/C0", cpu_ok, cpu_data); end
  endtask

  task automatic test_reset_midfetch();
    cpu_addr = 16'h0030;
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000118) begin bad++; $display("[TB] FAIL rmid_req got=%b/%h want=1/000118", sdram_req, sdram_addr); end
    rst = 1'b1;
    cpu_addr = 16'h0010;
    #1;
    total++; if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin bad++; $display("[TB] FAIL rmid_clear got=%b/%h want=0/000000", sdram_req, sdram_addr); end
    total++; if (cpu_ok !== 1'b0) begin bad++; $display("[TB] FAIL rmid_invalid got=%b want=0", cpu_ok); end
    cpu_cs = 1'b0;
    tick();
    rst = 1'b0;
    sdram_dst = 1'b1;
    sdram_data = 16'h9999;
    tick();
    sdram_dst = 1'b0;
    cpu_cs = 1'b1;
    cpu_addr = 16'h0030;
    #1;
    total++; if (cpu_ok !== 1'b0 || sdram_req !== 1'b0) begin bad++; $display("[TB] FAIL rmid_late_dst got=%b%b want=00", cpu_ok, sdram_req); end
    tick();
    total++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000118) begin bad++; $display("[TB] FAIL rmid_rereq got=%b/%h want=1/000118", sdram_req, sdram_addr); end
    handshake(16'h4321);
    total++; if (cpu_ok !== 1'b1 || cpu_data !== 8'h21) begin bad++; $display("[TB] FAIL rmid_fill got=%b/%h want=1/21", cpu_ok, cpu_data); end
  endtask

  task automatic test_wrap();
    w_cs = 1'b1;
    w_addr = 16'hFFFE;
    #1;
    total++; if (w_req !== 1'b0 || w_ok !== 1'b0) begin bad++; $display("[TB] FAIL wrap_pre got=%b%b want=00", w_req, w_ok); end
    tick();
    total++; if (w_req !== 1'b1) begin bad++; $display("[TB] FAIL wrap_req got=%b want=1", w_req); end
    total++; if (w_sdram_addr !== 22'h007FEF) begin bad++; $display("[TB] FAIL wrap_addr got=%h want=007FEF", w_sdram_addr); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_ack_dst_same();
    test_flush();
    test_addr_change();
    test_reset_midfetch();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
